l2_request_responder: RTL and testbench

L2_REQUEST_RESPONDER -- requirements
Module: l2_request_responder

---
 rtl/l2_request_responder.sv | 205 ++++++++++++++++++++
 tb/tb_l2_request_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_request_responder.sv
`default_nettype none
// ============================================================================
// Module      : l2_request_responder
// Description : Accepts L1 requests (read / write-back / RFO) into an
//               in-order FIFO, serves them one at a time with a fixed
//               L2 access latency, and presents each completed request on
//               a valid/ready response port.
//               Optional build macro L2_RESP_STATS_EN enables the
//               read/write-back/RFO completion counters; without it the
//               counters are tied to zero and no counter flops exist.
// Revision    : 1.0 - initial release
// ============================================================================
module l2_request_responder #(
   parameter int LATENCY = 4,   // L2 access cycles per request, 1..15
   parameter int DEPTH   = 4    // request FIFO entries, power of two, 2..16
) (
   input  logic        Clock,
   input  logic        clear,
   input  logic        l1_cmd_valid,
   input  logic [1:0]  command_to_L2,
   input  logic [25:0] addr_to_L2,
   output logic        l1_cmd_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [1:0]  resp_cmd,
   output logic [25:0] resp_addr,
   output logic        busy,
   output logic [31:0] read_count,
   output logic [31:0] write_count,
   output logic [31:0] rfo_count
);

   localparam int               c_AW   = $clog2(DEPTH);
   localparam int               c_CW   = c_AW + 1;
   localparam logic [c_CW-1:0]  c_FULL = c_CW'(DEPTH);
   localparam logic [3:0]       c_LAT  = 4'(LATENCY);

   localparam logic [1:0] c_CMD_READ = 2'd1;
   localparam logic [1:0] c_CMD_WB   = 2'd2;
   localparam logic [1:0] c_CMD_RFO  = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [27:0]       mem_q [DEPTH];
   logic [27:0]       mem_d [DEPTH];
   logic [c_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [c_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0]   count_q, count_d;
   logic [3:0]        lat_q, lat_d;
   logic [1:0]        hold_cmd_q, hold_cmd_d;
   logic [25:0]       hold_addr_q, hold_addr_d;

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_done;

   // Handshake qualifiers; ready comes only from registered occupancy so a
   // full FIFO never accepts, even on a cycle in which it is popped.
   assign w_full  = (count_q == c_FULL);
   assign w_empty = (count_q == '0);
   assign w_push  = l1_cmd_valid && !w_full && (command_to_L2 != 2'd0);
   assign w_pop   = (state_q == IDLE) && !w_empty;
   assign w_done  = (state_q == RESPOND) && resp_ready;

   assign l1_cmd_ready = !w_full;
   assign resp_valid   = (state_q == RESPOND);
   assign resp_cmd     = hold_cmd_q;
   assign resp_addr    = hold_addr_q;
   assign busy         = (state_q != IDLE) || !w_empty;

   // FIFO next state: write at tail, advance pointers, track occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         mem_d[wr_ptr_q] = {command_to_L2, addr_to_L2};
         wr_ptr_d        = wr_ptr_q + c_AW'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_AW'(1);
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_CW'(1);
         2'b01:   count_d = count_q - c_CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO storage; contents are qualified by occupancy so no reset is needed.
   always_ff @(posedge Clock) begin
      mem_q <= mem_d;
   end

   // FIFO pointer and occupancy registers.
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Request FSM: pop head, count down the access latency, hold the response.
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      hold_cmd_d  = hold_cmd_q;
      hold_addr_d = hold_addr_q;
      case (state_q)
         IDLE: begin
            if (w_pop) begin
               {hold_cmd_d, hold_addr_d} = mem_q[rd_ptr_q];
               lat_d                     = c_LAT;
               state_d                   = ACCESS;
            end
         end
         ACCESS: begin
            lat_d = lat_q - 4'd1;
            if (lat_q == 4'd1) begin
               state_d = RESPOND;
            end
         end
         RESPOND: begin
            if (w_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state, latency counter and response holding register.
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         state_q     <= IDLE;
         lat_q       <= 4'd0;
         hold_cmd_q  <= 2'd0;
         hold_addr_q <= 26'd0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         hold_cmd_q  <= hold_cmd_d;
         hold_addr_q <= hold_addr_d;
      end
   end

`ifdef L2_RESP_STATS_EN
   logic [31:0] read_count_q, read_count_d;
   logic [31:0] write_count_q, write_count_d;
   logic [31:0] rfo_count_q, rfo_count_d;

   // Bump the counter matching the command retired on the response handshake.
   always_comb begin
      read_count_d  = read_count_q;
      write_count_d = write_count_q;
      rfo_count_d   = rfo_count_q;
      if (w_done) begin
         case (hold_cmd_q)
            c_CMD_READ: read_count_d  = read_count_q + 32'd1;
            c_CMD_WB:   write_count_d = write_count_q + 32'd1;
            c_CMD_RFO:  rfo_count_d   = rfo_count_q + 32'd1;
            default:    ;
         endcase
      end
   end

   // Statistics registers; natural 32-bit wrap.
   always_ff @(posedge Clock or posedge clear) begin
      if (clear) begin
         read_count_q  <= 32'd0;
         write_count_q <= 32'd0;
         rfo_count_q   <= 32'd0;
      end else begin
         read_count_q  <= read_count_d;
         write_count_q <= write_count_d;
         rfo_count_q   <= rfo_count_d;
      end
   end

   assign read_count  = read_count_q;
   assign write_count = write_count_q;
   assign rfo_count   = rfo_count_q;
`else
   assign read_count  = 32'd0;
   assign write_count = 32'd0;
   assign rfo_count   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_request_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l2_request_responder
// Description : Self-checking bench for l2_request_responder: a response
//               scoreboard plus a vector table and directed corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_request_responder;

   localparam int LAT = 4;
   localparam int DEP = 4;

   logic        Clock = 1'b0;
   logic        clear;
   logic        l1_cmd_valid;
   logic [1:0]  command_to_L2;
   logic [25:0] addr_to_L2;
   logic        l1_cmd_ready;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_cmd;
   logic [25:0] resp_addr;
   logic        busy;
   logic [31:0] read_count;
   logic [31:0] write_count;
   logic [31:0] rfo_count;

   l2_request_responder #(.LATENCY(LAT), .DEPTH(DEP)) dut (
      .Clock         (Clock),
      .clear         (clear),
      .l1_cmd_valid  (l1_cmd_valid),
      .command_to_L2 (command_to_L2),
      .addr_to_L2    (addr_to_L2),
      .l1_cmd_ready  (l1_cmd_ready),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_cmd      (resp_cmd),
      .resp_addr     (resp_addr),
      .busy          (busy),
      .read_count    (read_count),
      .write_count   (write_count),
      .rfo_count     (rfo_count)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [25:0] addr;
   } exp_t;

   typedef struct {
      logic        v;
      logic [1:0]  c;
      logic [25:0] a;
      logic        exp_ready;
      logic        exp_push;
   } vec_t;

   exp_t        sb[$];
   vec_t        tbl[16];
   int          n_vec  = 0;
   int          n_miss = 0;
   int unsigned m_rd   = 0;
   int unsigned m_wb   = 0;
   int unsigned m_rfo  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ec(input int unsigned v);
`ifdef L2_RESP_STATS_EN
      return 32'(v);
`else
      return 32'd0 & 32'(v);
`endif
   endfunction

   task automatic step();
      @(posedge Clock);
      #2;
   endtask

   task automatic wait_valid(input int budget);
      int cnt = 0;
      while (resp_valid !== 1'b1 && cnt < budget) begin
         step();
         cnt++;
      end
      check("wait_resp_valid", 32'(resp_valid), 32'd1);
   endtask

   task automatic drain_and_check(input string tag);
      int cnt = 0;
      while (sb.size() != 0 && cnt < 300) begin
         step();
         cnt++;
      end
      check({tag, "_drain_left"}, 32'(sb.size()), 32'd0);
      repeat (3) step();
      check({tag, "_busy"},  32'(busy),   32'd0);
      check({tag, "_rd_cnt"},  read_count,  ec(m_rd));
      check({tag, "_wb_cnt"},  write_count, ec(m_wb));
      check({tag, "_rfo_cnt"}, rfo_count,   ec(m_rfo));
   endtask

   // Response monitor: every handshake must match the oldest expectation.
   always @(negedge Clock) begin
      if (clear === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_resp: got cmd %0h addr %0h expected none", resp_cmd, resp_addr);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_cmd",  32'(resp_cmd),  32'(e.cmd));
            check("resp_addr", 32'(resp_addr), 32'(e.addr));
            case (e.cmd)
               2'd1:    m_rd++;
               2'd2:    m_wb++;
               2'd3:    m_rfo++;
               default: ;
            endcase
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = '{1'b1, 2'd2, 26'h0000010, 1'b1, 1'b1};
      tbl[1]  = '{1'b1, 2'd3, 26'h0000020, 1'b1, 1'b1};
      tbl[2]  = '{1'b1, 2'd1, 26'h0000030, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 2'd0, 26'h3FFFFFF, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 2'd0, 26'h0000000, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 2'd0, 26'h0000000, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 2'd0, 26'h0000000, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 2'd0, 26'h0000000, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 2'd1, 26'h3FFFFFF, 1'b1, 1'b1};
      tbl[9]  = '{1'b1, 2'd2, 26'h0000000, 1'b1, 1'b1};
      tbl[10] = '{1'b1, 2'd3, 26'h2AAAAAA, 1'b1, 1'b1};
      tbl[11] = '{1'b1, 2'd1, 26'h1555555, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 2'd1, 26'h1555555, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 2'd1, 26'h1555555, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 2'd1, 26'h1555555, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 2'd0, 26'h0000000, 1'b0, 1'b0};

      clear         = 1'b1;
      l1_cmd_valid  = 1'b0;
      command_to_L2 = 2'd0;
      addr_to_L2    = 26'd0;
      resp_ready    = 1'b0;
      step();
      step();
      check("rst_ready",      32'(l1_cmd_ready), 32'd1);
      check("rst_busy",       32'(busy),         32'd0);
      check("rst_resp_valid", 32'(resp_valid),   32'd0);
      check("rst_resp_cmd",   32'(resp_cmd),     32'd0);
      check("rst_resp_addr",  32'(resp_addr),    32'd0);
      check("rst_rd_cnt",     read_count,        32'd0);
      check("rst_wb_cnt",     write_count,       32'd0);
      check("rst_rfo_cnt",    rfo_count,         32'd0);
      clear = 1'b0;
      step();

      // Single read: latency from accept edge to resp_valid.
      l1_cmd_valid  = 1'b1;
      command_to_L2 = 2'd1;
      addr_to_L2    = 26'h0001234;
      check("single_ready", 32'(l1_cmd_ready), 32'd1);
      sb.push_back('{2'd1, 26'h0001234});
      step();
      l1_cmd_valid = 1'b0;
      for (int k = 1; k <= LAT + 1; k++) begin
         step();
         check($sformatf("latency_edge%0d", k), 32'(resp_valid), 32'(k == LAT + 1));
      end
      check("single_cmd",  32'(resp_cmd),  32'd1);
      check("single_addr", 32'(resp_addr), 32'h0001234);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("single_valid_drop", 32'(resp_valid), 32'd0);
      check("single_rd_cnt",     read_count,      ec(1));

      // Valid with no-op command must be ignored.
      l1_cmd_valid  = 1'b1;
      command_to_L2 = 2'd0;
      addr_to_L2    = 26'h3FFFFFF;
      for (int k = 0; k < 4; k++) begin
         step();
         check("nop_busy", 32'(busy), 32'd0);
      end
      l1_cmd_valid = 1'b0;
      check("nop_rd_cnt",  read_count,  ec(1));
      check("nop_wb_cnt",  write_count, 32'd0);
      check("nop_rfo_cnt", rfo_count,   32'd0);

      // Response back-pressure while the FIFO fills to capacity.
      l1_cmd_valid  = 1'b1;
      command_to_L2 = 2'd1;
      addr_to_L2    = 26'h0000100;
      sb.push_back('{2'd1, 26'h0000100});
      step();
      l1_cmd_valid = 1'b0;
      wait_valid(20);
      for (int i = 0; i < 10; i++) begin
         if (i < 5) begin
            l1_cmd_valid  = 1'b1;
            command_to_L2 = 2'((i % 3) + 1);
            addr_to_L2    = 26'h0000200 + 26'(i);
            check($sformatf("bp_ready%0d", i), 32'(l1_cmd_ready), 32'(i < DEP));
            if (i < DEP) sb.push_back('{2'((i % 3) + 1), 26'h0000200 + 26'(i)});
         end else begin
            l1_cmd_valid = 1'b0;
         end
         step();
         check("bp_valid_held", 32'(resp_valid), 32'd1);
         check("bp_cmd_held",   32'(resp_cmd),   32'd1);
         check("bp_addr_held",  32'(resp_addr),  32'h0000100);
      end
      l1_cmd_valid = 1'b0;
      resp_ready   = 1'b1;
      drain_and_check("bp");

      // Vector table with the response side always ready.
      for (int i = 0; i < 16; i++) begin
         l1_cmd_valid  = tbl[i].v;
         command_to_L2 = tbl[i].c;
         addr_to_L2    = tbl[i].a;
         check($sformatf("tbl%0d_ready", i), 32'(l1_cmd_ready), 32'(tbl[i].exp_ready));
         if (tbl[i].exp_push) sb.push_back('{tbl[i].c, tbl[i].a});
         step();
      end
      l1_cmd_valid = 1'b0;
      drain_and_check("tbl");

      // Reset in the middle of an access with two requests queued.
      resp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         l1_cmd_valid  = 1'b1;
         command_to_L2 = 2'd1;
         addr_to_L2    = 26'h0000040 + 26'(i);
         step();
      end
      l1_cmd_valid = 1'b0;
      step();
      check("mid_busy_before", 32'(busy), 32'd1);
      #1 clear = 1'b1;
      #1;
      check("mid_rst_valid", 32'(resp_valid),   32'd0);
      check("mid_rst_busy",  32'(busy),         32'd0);
      check("mid_rst_ready", 32'(l1_cmd_ready), 32'd1);
      step();
      clear = 1'b0;
      m_rd  = 0;
      m_wb  = 0;
      m_rfo = 0;
      resp_ready = 1'b1;
      repeat (20) step();
      check("post_rst_busy",    32'(busy),   32'd0);
      check("post_rst_rd_cnt",  read_count,  32'd0);
      check("post_rst_wb_cnt",  write_count, 32'd0);
      check("post_rst_rfo_cnt", rfo_count,   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
